dff_pipe_bank: RTL and testbench

- Parametrised register pipeline built from generic flop behaviour: DEPTH stages of WIDTH-bit data, each stage with its own valid bit.
- Adds what single-bit flop cells lack: valid/ready flow control with bubble collapsing, a global clock enable, a sync clear with selectable enable gating (SDFF vs SDFFCE style), and an occupancy count.
- Used as the reference generic pipeline stage for mapping and legalisation tests and for retiming datapaths.

---
 rtl/dff_pipe_bank_pkg.sv | 21 ++
 rtl/dff_pipe_slice.sv | 40 ++++
 rtl/dff_pipe_bank.sv | 98 +++++++++
 tb/tb_dff_pipe_bank.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_pipe_bank_pkg.sv
// Shared types and helpers for the dff_pipe_bank register pipeline.
// Holds the count width rule, per-stage action priority and sync-clear mode constants.
package dff_pipe_bank_pkg;

  // Sync clear gating modes: ungated clear overrides E, gated clear needs E=1.
  localparam bit SRST_UNGATED = 1'b0;
  localparam bit SRST_GATED   = 1'b1;

  // Stage actions in priority order; PRI_ARST is only ever reached through R.
  typedef enum logic [1:0] {
    PRI_ARST = 2'd0,
    PRI_SRST = 2'd1,
    PRI_HOLD = 2'd2,
    PRI_LOAD = 2'd3
  } stage_act_e;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_pipe_slice.sv
// One pipeline stage: WIDTH data bits plus a valid bit.
// Async reset loads ARST_VAL, sync clear loads SRST_VAL, otherwise load or hold per act.
module dff_pipe_slice
  import dff_pipe_bank_pkg::*;
#(
  parameter int unsigned       WIDTH    = 8,
  parameter logic [WIDTH-1:0]  ARST_VAL = '0,
  parameter logic [WIDTH-1:0]  SRST_VAL = '0
) (
  input  logic             C,
  input  logic             R,
  input  stage_act_e       act,
  input  logic [WIDTH-1:0] src_data,
  input  logic             src_valid,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // its neighbour's pre-edge value and the pipeline shifts by exactly one slot.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      data  <= ARST_VAL;
      valid <= 1'b0;
    end else begin
      case (act)
        PRI_SRST: begin
          data  <= SRST_VAL;
          valid <= 1'b0;
        end
        PRI_LOAD: begin
          data  <= src_data;
          valid <= src_valid;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dff_pipe_bank.sv
// Parametrised valid/ready register pipeline with bubble collapsing, global enable,
// selectable sync-clear gating and a registered occupancy count.
module dff_pipe_bank
  import dff_pipe_bank_pkg::*;
#(
  parameter int unsigned       WIDTH      = 8,
  parameter int unsigned       DEPTH      = 4,
  parameter logic [WIDTH-1:0]  ARST_VAL   = '0,
  parameter logic [WIDTH-1:0]  SRST_VAL   = '0,
  parameter bit                SRST_GATED = 1'b0
) (
  input  logic                              C,
  input  logic                              R,
  input  logic                              E,
  input  logic                              SR,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WIDTH-1:0]                  in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [WIDTH-1:0]                  out_data,
  output logic [count_width(DEPTH)-1:0]     count
);

  localparam int unsigned CW = count_width(DEPTH);

  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0] stage_valid;
  logic [DEPTH-1:0] adv;
  logic             clr;
  logic             accept;
  logic             pop;

  assign clr = SR & ((SRST_GATED == dff_pipe_bank_pkg::SRST_UNGATED) | E);

  // Ready chain from the output end back: an empty stage always advances.
  // NOTE: every variable written here gets a value before any branch or loop,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    logic chain;
    chain = out_ready;
    adv   = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      chain  = E & (~stage_valid[i] | chain);
      adv[i] = chain;
    end
  end

  assign in_ready  = adv[0];
  assign accept    = in_valid & adv[0];
  assign pop       = stage_valid[DEPTH-1] & adv[DEPTH-1];
  assign out_valid = stage_valid[DEPTH-1];
  assign out_data  = stage_data[DEPTH-1];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] src_data;
    logic             src_valid;
    stage_act_e       act;

    if (i == 0) begin : g_head
      assign src_data  = in_data;
      assign src_valid = in_valid;
    end else begin : g_body
      assign src_data  = stage_data[i-1];
      assign src_valid = stage_valid[i-1];
    end

    assign act = clr ? PRI_SRST : (adv[i] ? PRI_LOAD : PRI_HOLD);

    dff_pipe_slice #(
      .WIDTH    (WIDTH),
      .ARST_VAL (ARST_VAL),
      .SRST_VAL (SRST_VAL)
    ) u_slice (
      .C         (C),
      .R         (R),
      .act       (act),
      .src_data  (src_data),
      .src_valid (src_valid),
      .data      (stage_data[i]),
      .valid     (stage_valid[i])
    );
  end

  // Occupancy moves only on an unmatched accept or pop; a clear drops everything.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (accept & ~pop) begin
      count <= count + CW'(1);
    end else if (pop & ~accept) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_dff_pipe_bank.sv
// Self-checking bench for dff_pipe_bank: directed scenarios plus randomized traffic
// against a token-position model of the pipeline (one DUT per sync-clear mode).
module tb_dff_pipe_bank;

  localparam int DEPTH = 4;
  localparam int WIDTH = 8;

  logic             C = 1'b0;
  logic             R, E, SR, in_valid, out_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_ready, out_valid;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       count;
  logic             g_in_ready, g_out_valid;
  logic [WIDTH-1:0] g_out_data;
  logic [2:0]       g_count;

  int n_checks = 0;
  int n_errors = 0;

  // Model: words in flight, oldest first, each with its stage position.
  logic [WIDTH-1:0] mq_data[$];
  int               mq_pos[$];

  always #5 C = ~C;

  dff_pipe_bank #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ARST_VAL(8'hA5), .SRST_VAL(8'h3C), .SRST_GATED(1'b0)
  ) u_dut (
    .C(C), .R(R), .E(E), .SR(SR),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  dff_pipe_bank #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ARST_VAL(8'hA5), .SRST_VAL(8'h3C), .SRST_GATED(1'b1)
  ) u_dut_g (
    .C(C), .R(R), .E(E), .SR(SR),
    .in_valid(in_valid), .in_ready(g_in_ready), .in_data(in_data),
    .out_valid(g_out_valid), .out_ready(out_ready), .out_data(g_out_data),
    .count(g_count)
  );

  function automatic bit m_in_ready();
    return E && (mq_pos.size() < DEPTH || out_ready);
  endfunction

  function automatic bit m_valid();
    return mq_pos.size() > 0 && mq_pos[0] == DEPTH - 1;
  endfunction

  function automatic logic [WIDTH-1:0] m_data();
    return (mq_data.size() > 0) ? mq_data[0] : '0;
  endfunction

  function automatic logic [2:0] m_count();
    return 3'(mq_pos.size());
  endfunction

  task automatic model_clear();
    mq_pos.delete();
    mq_data.delete();
  endtask

  // One clock: from a falling edge through the rising edge to the next falling edge.
  task automatic step();
    bit               acc, moved_ahead, stay;
    int               old_ahead, p;
    int               np[$];
    logic [WIDTH-1:0] nd[$];
    acc = in_valid && m_in_ready();
    @(posedge C);
    if (SR) begin
      model_clear();
    end else if (E) begin
      moved_ahead = 1'b1;
      old_ahead   = DEPTH;
      for (int k = 0; k < mq_pos.size(); k++) begin
        p = mq_pos[k];
        if (k == 0) stay = (p == DEPTH - 1) && !out_ready;
        else        stay = !moved_ahead && (old_ahead == p + 1);
        if (stay) begin
          np.push_back(p);
          nd.push_back(mq_data[k]);
        end else if (p + 1 < DEPTH) begin
          np.push_back(p + 1);
          nd.push_back(mq_data[k]);
        end
        moved_ahead = !stay;
        old_ahead   = p;
      end
      if (acc) begin
        np.push_back(0);
        nd.push_back(in_data);
      end
      mq_pos  = np;
      mq_data = nd;
    end
    @(negedge C);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid  = 1'($urandom);
      in_data   = 8'($urandom);
      out_ready = 1'($urandom);
      E         = 1'($urandom);
      @(negedge C);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
      end
      n_checks++;
      if (count !== 3'd0 || g_count !== 3'd0) begin
        n_errors++; $display("FAIL reset_count: got %0d/%0d want 0", count, g_count);
      end
      n_checks++;
      if (out_data !== 8'hA5 || g_out_data !== 8'hA5) begin
        n_errors++; $display("FAIL reset_data: got %h/%h want a5", out_data, g_out_data);
      end
    end
    R = 1'b1; E = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    model_clear();
  endtask

  task automatic test_latency();
    in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++; $display("FAIL lat_in_ready: got %b want 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      step();
      n_checks++;
      if (out_valid !== (j == 3)) begin
        n_errors++; $display("FAIL lat_out_valid_edge%0d: got %b want %b", j, out_valid, j == 3);
      end
    end
    n_checks++;
    if (out_data !== 8'h11) begin
      n_errors++; $display("FAIL lat_out_data: got %h want 11", out_data);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      n_errors++; $display("FAIL lat_drain: got valid=%b count=%0d want 0/0", out_valid, count);
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] words [5];
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      words[i] = 8'($urandom);
      in_valid = 1'b1; in_data = words[i];
      #1;
      n_checks++;
      if (in_ready !== (i < 4)) begin
        n_errors++; $display("FAIL bp_in_ready_%0d: got %b want %b", i, in_ready, i < 4);
      end
      step();
    end
    in_valid = 1'b0;
    n_checks++;
    if (count !== 3'd4 || g_count !== 3'd4) begin
      n_errors++; $display("FAIL bp_full_count: got %0d/%0d want 4", count, g_count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== words[i]) begin
        n_errors++; $display("FAIL bp_pop_%0d: got %b/%h want 1/%h", i, out_valid, out_data, words[i]);
      end
      step();
    end
    n_checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      n_errors++; $display("FAIL bp_empty: got count=%0d valid=%b want 0/0", count, out_valid);
    end
  endtask

  task automatic test_bubbles();
    logic [WIDTH-1:0] wa, wb;
    wa = 8'($urandom); wb = 8'($urandom);
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 7; cyc++) begin
      in_valid = (cyc == 0 || cyc == 3);
      in_data  = (cyc == 0) ? wa : wb;
      step();
    end
    in_valid = 1'b0;
    n_checks++;
    if (count !== 3'd2) begin
      n_errors++; $display("FAIL bub_count: got %0d want 2", count);
    end
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== wa) begin
      n_errors++; $display("FAIL bub_head: got %b/%h want 1/%h", out_valid, out_data, wa);
    end
    out_ready = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== wb) begin
      n_errors++; $display("FAIL bub_no_gap: got %b/%h want 1/%h", out_valid, out_data, wb);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      n_errors++; $display("FAIL bub_drain: got valid=%b count=%0d want 0/0", out_valid, count);
    end
  endtask

  task automatic test_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i < 3);
      in_data  = 8'($urandom);
      step();
    end
    n_checks++;
    if (count !== 3'd3 || g_count !== 3'd3) begin
      n_errors++; $display("FAIL clr_pre_count: got %0d/%0d want 3", count, g_count);
    end
    SR = 1'b1; E = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    step();
    n_checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== 8'h3C) begin
      n_errors++; $display("FAIL clr_ungated: got count=%0d valid=%b data=%h want 0/0/3c", count, out_valid, out_data);
    end
    n_checks++;
    if (g_count !== 3'd3 || g_out_valid !== 1'b1) begin
      n_errors++; $display("FAIL clr_gated_hold: got count=%0d valid=%b want 3/1", g_count, g_out_valid);
    end
    E = 1'b1;
    step();
    n_checks++;
    if (g_count !== 3'd0 || g_out_valid !== 1'b0 || g_out_data !== 8'h3C) begin
      n_errors++; $display("FAIL clr_gated: got count=%0d valid=%b data=%h want 0/0/3c", g_count, g_out_valid, g_out_data);
    end
    n_checks++;
    if (count !== 3'd0) begin
      n_errors++; $display("FAIL clr_discard_handshake: got count=%0d want 0", count);
    end
    SR = 1'b0; in_valid = 1'b0;
    model_clear();
  endtask

  task automatic test_hold();
    int pops;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom);
      step();
    end
    E = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom);
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_errors++; $display("FAIL hold_in_ready_%0d: got %b want 0", i, in_ready);
      end
      step();
      n_checks++;
      if (count !== 3'd2 || out_valid !== m_valid()) begin
        n_errors++; $display("FAIL hold_state_%0d: got count=%0d valid=%b want 2/%b", i, count, out_valid, m_valid());
      end
    end
    E = 1'b1; in_valid = 1'b0; pops = 0;
    for (int i = 0; i < 6; i++) begin
      if (m_valid()) begin
        pops++;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== m_data()) begin
          n_errors++; $display("FAIL hold_drain_%0d: got %b/%h want 1/%h", i, out_valid, out_data, m_data());
        end
      end
      step();
    end
    n_checks++;
    if (pops != 2 || count !== 3'd0) begin
      n_errors++; $display("FAIL hold_no_loss: got pops=%0d count=%0d want 2/0", pops, count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      E         = ($urandom_range(0, 9) != 0);
      SR        = E && ($urandom_range(0, 39) == 0);
      in_valid  = 1'($urandom);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      n_checks++;
      if (in_ready !== m_in_ready()) begin
        n_errors++; $display("FAIL rnd_in_ready_%0d: got %b want %b", i, in_ready, m_in_ready());
      end
      step();
      n_checks++;
      if (count !== m_count() || g_count !== m_count()) begin
        n_errors++; $display("FAIL rnd_count_%0d: got %0d/%0d want %0d", i, count, g_count, m_count());
      end
      n_checks++;
      if (out_valid !== m_valid() || (m_valid() && out_data !== m_data())) begin
        n_errors++; $display("FAIL rnd_out_%0d: got %b/%h want %b/%h", i, out_valid, out_data, m_valid(), m_data());
      end
    end
    SR = 1'b0; E = 1'b1; in_valid = 1'b0;
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom);
      step();
    end
    n_checks++;
    if (count !== 3'd4) begin
      n_errors++; $display("FAIL mr_full: got %0d want 4", count);
    end
    out_ready = 1'b1; in_data = 8'($urandom);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++; $display("FAIL mr_full_in_ready: got %b want 1", in_ready);
    end
    step();
    n_checks++;
    if (count !== 3'd4 || out_valid !== 1'b1 || out_data !== m_data()) begin
      n_errors++; $display("FAIL mr_accept_pop: got count=%0d data=%h want 4/%h", count, out_data, m_data());
    end
    in_data = 8'($urandom);
    #1 R = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || count !== 3'd0 || g_count !== 3'd0) begin
      n_errors++; $display("FAIL mr_immediate: got valid=%b count=%0d/%0d want 0/0", out_valid, count, g_count);
    end
    #1 R = 1'b1;
    model_clear();
    in_valid = 1'b1; in_data = 8'h77;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (count !== 3'd1) begin
      n_errors++; $display("FAIL mr_first_accept: got %0d want 1", count);
    end
    for (int j = 0; j < 3; j++) step();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h77) begin
      n_errors++; $display("FAIL mr_after_release: got %b/%h want 1/77", out_valid, out_data);
    end
  endtask

  initial begin
    R = 1'b1; E = 1'b1; SR = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #2 R = 1'b0;
    test_reset();
    test_latency();
    test_backpressure();
    test_bubbles();
    test_clear();
    test_hold();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
